seq_det_stream_ctrl: RTL and testbench

Controller that feeds a bit-serial 1010 Mealy non-overlap detector from a parallel word stream. Accepts words over a valid/ready handshake, serializes them one bit per enabled cycle, and steps the detector core. Counts detections against a programmable threshold and raises a sticky interrupt. Sits between a byte-wide source (UART RX, packet buffer) and CPU-visible status.

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_det_stream_ctrl_if.sv | 11 +
 rtl/seq_det_1010_step.sv | 39 +++
 rtl/seq_det_stream_ctrl.sv | 123 ++++++++++++
 tb/tb_seq_det_stream_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared types for the 1010 stream detector: controller FSM states and
// detector core state encoding.
package seq_det_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ctrl_state_e;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } det_state_e;

endpackage

// File: rtl/seq_det_stream_ctrl_if.sv
// Valid/ready word stream feeding the serializer.
interface seq_det_stream_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/seq_det_1010_step.sv
// 1010 Mealy non-overlap detector; advances only when step is high,
// clr forces S0 at the next edge.
module seq_det_1010_step
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic clr,
  input  logic bit_in,
  output logic det
);

  det_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    det     = 1'b0;
    if (step) begin
      case (state_q)
        S0: state_d = bit_in ? S1 : S0;
        S1: state_d = bit_in ? S1 : S2;
        S2: state_d = bit_in ? S3 : S0;
        S3: begin
          // A completed match restarts from S0 so matches never share bits.
          state_d = bit_in ? S1 : S0;
          det     = ~bit_in;
        end
      endcase
    end
    if (clr) state_d = S0;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S0;
    else     state_q <= state_d;
  end

endmodule

// File: rtl/seq_det_stream_ctrl.sv
// Word-to-bit serializer driving a 1010 detector, with saturating
// detection counter and sticky threshold interrupt.
module seq_det_stream_ctrl
  import seq_det_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int SPAN_WORDS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  seq_det_stream_ctrl_if.slave  s,
  input  logic [CNT_W-1:0]      threshold,
  input  logic                  clr_cnt,
  output logic                  busy,
  output logic                  det_pulse,
  output logic [CNT_W-1:0]      det_count,
  output logic                  irq
);

  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

  ctrl_state_e       state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic              det_pulse_q, det_pulse_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              irq_q, irq_d;

  logic last_bit, ready, accept, step, cur_bit, det, det_clr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign last_bit = (bit_cnt_q == LAST_BIT);
  assign ready    = en & ~rst & ((state_q == IDLE) | ((state_q == SHIFT) & last_bit));
  assign accept   = s.s_valid & ready;
  assign step     = (state_q == SHIFT) & en;
  assign cur_bit  = (MSB_FIRST != 0) ? shreg_q[DATA_W-1] : shreg_q[0];
  assign det_clr  = accept & (SPAN_WORDS == 0);
  assign cnt_inc  = sat_inc(cnt_q);

  assign s.s_ready = ready;
  assign busy      = (state_q == SHIFT);
  assign det_pulse = det_pulse_q;
  assign det_count = cnt_q;
  assign irq       = irq_q;

  seq_det_1010_step u_core (
    .clk    (clk),
    .rst    (rst),
    .step   (step),
    .clr    (det_clr),
    .bit_in (cur_bit),
    .det    (det)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SHIFT;
          shreg_d   = s.s_data;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (en) begin
          shreg_d   = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          if (last_bit) begin
            // Reload on the last bit keeps one bit per cycle with no bubble.
            bit_cnt_d = '0;
            if (accept) shreg_d = s.s_data;
            else        state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    det_pulse_d = det;
    cnt_d       = cnt_q;
    irq_d       = irq_q;
    if (det) begin
      cnt_d = cnt_inc;
      if ((threshold != '0) && (cnt_inc >= threshold)) irq_d = 1'b1;
    end
    // Clear has priority over a coincident detection; the pulse still fires.
    if (clr_cnt) begin
      cnt_d = '0;
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      det_pulse_q <= 1'b0;
      cnt_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      det_pulse_q <= det_pulse_d;
      cnt_q       <= cnt_d;
      irq_q       <= irq_d;
    end
  end

endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// Directed bench for seq_det_stream_ctrl: three configurations (spanning,
// per-word reset, 2-bit counter) driven by shared per-cycle stimulus tables.
module tb_seq_det_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic [7:0] threshold = 8'h00;
  logic [1:0] thr_c;
  logic       clr_cnt = 1'b0;

  logic       busy_a, det_pulse_a, irq_a;
  logic [7:0] det_count_a;
  logic       busy_b, det_pulse_b, irq_b;
  logic [7:0] det_count_b;
  logic       busy_c, det_pulse_c, irq_c;
  logic [1:0] det_count_c;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_det_stream_ctrl_if #(.DATA_W(8)) if_a ();
  seq_det_stream_ctrl_if #(.DATA_W(8)) if_b ();
  seq_det_stream_ctrl_if #(.DATA_W(8)) if_c ();

  assign if_a.s_valid = s_valid;
  assign if_a.s_data  = s_data;
  assign if_b.s_valid = s_valid;
  assign if_b.s_data  = s_data;
  assign if_c.s_valid = s_valid;
  assign if_c.s_data  = s_data;
  assign thr_c        = threshold[1:0];

  seq_det_stream_ctrl #(.DATA_W(8), .CNT_W(8), .MSB_FIRST(1), .SPAN_WORDS(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .s(if_a), .threshold(threshold), .clr_cnt(clr_cnt),
    .busy(busy_a), .det_pulse(det_pulse_a), .det_count(det_count_a), .irq(irq_a));

  seq_det_stream_ctrl #(.DATA_W(8), .CNT_W(8), .MSB_FIRST(1), .SPAN_WORDS(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .s(if_b), .threshold(threshold), .clr_cnt(clr_cnt),
    .busy(busy_b), .det_pulse(det_pulse_b), .det_count(det_count_b), .irq(irq_b));

  seq_det_stream_ctrl #(.DATA_W(8), .CNT_W(2), .MSB_FIRST(1), .SPAN_WORDS(1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .s(if_c), .threshold(thr_c), .clr_cnt(clr_cnt),
    .busy(busy_c), .det_pulse(det_pulse_c), .det_count(det_count_c), .irq(irq_c));

  // Per-cycle stimulus tables, index = cycle number relative to c0.
  logic       tv [32];
  logic [7:0] td [32];
  logic       te [32];
  logic       tc [32];
  logic       tr [32];

  // Per-cycle observations, bit k = value seen in cycle ck.
  logic [31:0] m_pa, m_pb, m_pc, m_ra, m_ba, m_ia;
  logic [7:0]  ca [32];
  logic [1:0]  cc [32];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_tab();
    for (int i = 0; i < 32; i++) begin
      tv[i] = 1'b0; td[i] = 8'h00; te[i] = 1'b1; tc[i] = 1'b0; tr[i] = 1'b0;
    end
  endtask

  task automatic play(input int n);
    m_pa = '0; m_pb = '0; m_pc = '0; m_ra = '0; m_ba = '0; m_ia = '0;
    for (int k = 0; k < n; k++) begin
      s_valid = tv[k]; s_data = td[k]; en = te[k]; clr_cnt = tc[k]; rst = tr[k];
      @(negedge clk);
      m_pa[k] = det_pulse_a;
      m_pb[k] = det_pulse_b;
      m_pc[k] = det_pulse_c;
      m_ra[k] = if_a.s_ready;
      m_ba[k] = busy_a;
      m_ia[k] = irq_a;
      ca[k]   = det_count_a;
      cc[k]   = det_count_c;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; en = 1'b1; clr_cnt = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; en = 1'b1; s_valid = 1'b1; s_data = 8'hFF; clr_cnt = 1'b0;
    @(negedge clk);
    check_eq({tag, "_ready_in_rst"}, 32'(if_a.s_ready), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq({tag, "_rst_outs"},
             {20'h0, busy_a, det_pulse_a, irq_a, 1'b0, det_count_a}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0;
  endtask

  initial begin
    // 0xA0: single detection, pulse in c5, busy c1..c8
    do_reset("t1");
    clear_tab();
    tv[0] = 1'b1; td[0] = 8'hA0;
    play(12);
    check_eq("t1_pulse_a", m_pa, 32'h20);
    check_eq("t1_pulse_b", m_pb, 32'h20);
    check_eq("t1_pulse_c", m_pc, 32'h20);
    check_eq("t1_busy_a", m_ba, 32'h1FE);
    check_eq("t1_cnt_a", 32'(ca[11]), 32'd1);

    // 0xAA: non-overlap gives two pulses, not three
    do_reset("t2");
    clear_tab();
    tv[0] = 1'b1; td[0] = 8'hAA;
    play(12);
    check_eq("t2_pulse_a", m_pa, 32'h220);
    check_eq("t2_cnt_a", 32'(ca[11]), 32'd2);
    check_eq("t2_cnt_c", 32'(cc[11]), 32'd2);

    // 0x05 then 0x7F back to back: match spans the word boundary only when spanning
    do_reset("t3");
    clear_tab();
    tv[0] = 1'b1; td[0] = 8'h05;
    for (int k = 1; k <= 8; k++) begin tv[k] = 1'b1; td[k] = 8'h7F; end
    play(19);
    check_eq("t3_ready_a", m_ra & 32'h3FF, 32'h101);
    check_eq("t3_busy_a", m_ba, 32'h1FFFE);
    check_eq("t3_pulse_a", m_pa, 32'h400);
    check_eq("t3_pulse_b", m_pb, 32'h0);
    check_eq("t3_cnt_a", 32'(ca[18]), 32'd1);
    check_eq("t3_cnt_b", 32'(det_count_b), 32'd0);

    // 0xAA stalled three cycles after bit 2, then en low while idle with valid high
    do_reset("t4");
    clear_tab();
    tv[0] = 1'b1; td[0] = 8'hAA;
    te[4] = 1'b0; te[5] = 1'b0; te[6] = 1'b0;
    te[14] = 1'b0; tv[14] = 1'b1; td[14] = 8'hFF;
    play(16);
    check_eq("t4_pulse_a", m_pa, 32'h1100);
    check_eq("t4_busy_a", m_ba, 32'h0FFE);
    check_eq("t4_ready_a", m_ra & 32'hFFFF, 32'hB801);
    check_eq("t4_cnt_a", 32'(ca[15]), 32'd2);

    // threshold 2: irq rises with the second detection, clr_cnt drops it
    do_reset("t5");
    threshold = 8'd2;
    clear_tab();
    tv[0] = 1'b1; td[0] = 8'hAA;
    tc[12] = 1'b1;
    play(14);
    check_eq("t5_pulse_a", m_pa, 32'h220);
    check_eq("t5_cnt_c5", 32'(ca[5]), 32'd1);
    check_eq("t5_cnt_c9", 32'(ca[9]), 32'd2);
    check_eq("t5_irq_a", m_ia, 32'h1E00);
    check_eq("t5_cnt_c13", 32'(ca[13]), 32'd0);

    // clr_cnt coincident with a detection: clear wins, pulse still fires
    threshold = 8'd1;
    clear_tab();
    tv[0] = 1'b1; td[0] = 8'hA0;
    tc[4] = 1'b1;
    play(8);
    check_eq("t5b_pulse_a", m_pa, 32'h20);
    check_eq("t5b_cnt_a", 32'(ca[5]), 32'd0);
    check_eq("t5b_irq_a", m_ia, 32'h0);

    // 2-bit counter saturates at 3, fourth pulse still visible; threshold 0 keeps irq low
    do_reset("t6");
    threshold = 8'd0;
    clear_tab();
    for (int k = 0; k <= 8; k++) begin tv[k] = 1'b1; td[k] = 8'hAA; end
    play(20);
    check_eq("t6_pulse_c", m_pc, 32'h22220);
    check_eq("t6_pulse_a", m_pa, 32'h22220);
    check_eq("t6_cnt_c", 32'(cc[19]), 32'd3);
    check_eq("t6_cnt_a", 32'(ca[19]), 32'd4);
    check_eq("t6_irq_a", m_ia, 32'h0);

    // rst mid-word after bits 1,0,1: word and detector state discarded
    clear_tab();
    tv[0] = 1'b1; td[0] = 8'hAA;
    tr[3] = 1'b1; tv[3] = 1'b1; td[3] = 8'hAA;
    tv[5] = 1'b1; td[5] = 8'h00;
    play(16);
    check_eq("t7_cnt_a_c3", 32'(ca[3]), 32'd4);
    check_eq("t7_cnt_c_c3", 32'(cc[3]), 32'd3);
    check_eq("t7_cnt_a_c4", 32'(ca[4]), 32'd0);
    check_eq("t7_cnt_c_c4", 32'(cc[4]), 32'd0);
    check_eq("t7_busy_a", m_ba & 32'h1F, 32'h0E);
    check_eq("t7_ready_a", m_ra & 32'h3F, 32'h31);
    check_eq("t7_pulse_a", m_pa, 32'h0);
    check_eq("t7_pulse_c", m_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
